// File: rtl/axi_burst_pkg.sv
// Shared encodings, limits and helpers for the AXI burst address generator.
package axi_burst_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    localparam int unsigned MAX_SIZE      = 2;
    localparam int unsigned BOUNDARY_BITS = 12;

    // Bit n set when a WRAP burst of AxLEN == n is legal (lengths 2, 4, 8, 16 beats).
    localparam logic [15:0] WRAP_LEN_SET = 16'h808A;

    function automatic logic wrap_len_legal(input logic [31:0] len);
        return (len < 32'd16) && WRAP_LEN_SET[len[3:0]];
    endfunction

endpackage

// File: rtl/axi_beat_addr_next.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_beat_addr_next #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    input  logic [ADDR_W-1:0] lower_i,
    input  logic [ADDR_W-1:0] wrap_bytes_i,
    output logic [ADDR_W-1:0] next_addr_o
);
    import axi_burst_pkg::*;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_next;
    logic [ADDR_W-1:0] wrap_sum;
    logic [ADDR_W-1:0] wrap_next;

    always_comb begin
        step      = ADDR_W'(1) << size_i;
        // Aligning first makes an unaligned beat 0 land on the next aligned slot.
        incr_next = (addr_i & ~(step - ADDR_W'(1))) + step;
        wrap_sum  = addr_i + step;
        wrap_next = (wrap_sum == lower_i + wrap_bytes_i) ? lower_i : wrap_sum;

        case (burst_i)
            BURST_INCR: next_addr_o = incr_next;
            BURST_WRAP: next_addr_o = wrap_next;
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one accepted AXI burst descriptor into a registered per-beat address stream.
module axi_burst_addr_gen #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned MAX_SIZE = axi_burst_pkg::MAX_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              beat_last,
    output logic              beat_err,
    output logic              busy
);
    import axi_burst_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lower_q, lower_d;
    logic [ADDR_W-1:0] wrap_bytes_q, wrap_bytes_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] cmd_step;
    logic [ADDR_W-1:0] cmd_bytes;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   incr_end;
    logic              cross_4k;
    logic              cmd_err;
    logic [ADDR_W-1:0] next_addr;

    // Descriptor legality; the extra top bit catches bursts running past 2^ADDR_W.
    always_comb begin
        cmd_step  = ADDR_W'(1) << cmd_size;
        cmd_bytes = (ADDR_W'(cmd_len) + ADDR_W'(1)) << cmd_size;
        cmd_base  = cmd_addr & ~(cmd_step - ADDR_W'(1));
        incr_end  = {1'b0, cmd_base} + {1'b0, cmd_bytes} - {{ADDR_W{1'b0}}, 1'b1};
        cross_4k  = incr_end[ADDR_W:BOUNDARY_BITS] != {1'b0, cmd_addr[ADDR_W-1:BOUNDARY_BITS]};
        cmd_err   = (32'(cmd_size) > MAX_SIZE)
                 || (cmd_burst == BURST_RSVD)
                 || ((cmd_burst == BURST_WRAP)
                     && (!wrap_len_legal(32'(cmd_len))
                         || ((cmd_addr & (cmd_step - ADDR_W'(1))) != '0)))
                 || ((cmd_burst == BURST_INCR) && cross_4k);
    end

    axi_beat_addr_next #(
        .ADDR_W (ADDR_W)
    ) u_addr_next (
        .addr_i       (addr_q),
        .size_i       (size_q),
        .burst_i      (burst_q),
        .lower_i      (lower_q),
        .wrap_bytes_i (wrap_bytes_q),
        .next_addr_o  (next_addr)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lower_d      = lower_q;
        wrap_bytes_d = wrap_bytes_q;
        idx_d        = idx_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        last_d       = last_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d      = StBurst;
                    addr_d       = cmd_addr;
                    lower_d      = cmd_addr & ~(cmd_bytes - ADDR_W'(1));
                    wrap_bytes_d = cmd_bytes;
                    idx_d        = '0;
                    len_d        = cmd_len;
                    size_d       = cmd_size;
                    burst_d      = cmd_burst;
                    last_d       = (cmd_len == '0);
                    err_d        = cmd_err;
                end
            end
            StBurst: begin
                if (beat_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        // Illegal bursts hold the start address so the datapath can drain.
                        addr_d = err_q ? addr_q : next_addr;
                        idx_d  = idx_q + LEN_W'(1);
                        last_d = (idx_q + LEN_W'(1)) == len_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            lower_q      <= '0;
            wrap_bytes_q <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lower_q      <= lower_d;
            wrap_bytes_q <= wrap_bytes_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q == StBurst);
    assign beat_valid = (state_q == StBurst);
    assign beat_addr  = addr_q;
    assign beat_idx   = idx_q;
    assign beat_last  = last_q;
    assign beat_err   = err_q;

endmodule
